// File: rtl/fp_addsub_pkg.sv
// rtl/fp_addsub_pkg.sv - shared width, op encoding and tag type for the FP add/sub arbiter
package fp_addsub_pkg;

    localparam int WIDTH = 32;

    typedef enum logic {
        FP_ADD = 1'b0,
        FP_SUB = 1'b1
    } fp_op_e;

    // One in-flight operation: occupied flag plus the requester that issued it
    typedef struct packed {
        logic valid;
        logic id;
    } fpas_tag_t;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// rtl/fp_addsub_arbiter_if.sv - request, core and response signal bundle for the FP add/sub arbiter
interface fp_addsub_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_op;
    logic             req1_op;
    logic [WIDTH-1:0] fpu_a;
    logic [WIDTH-1:0] fpu_b;
    logic             fpu_op;
    logic [WIDTH-1:0] fpu_result;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic [WIDTH-1:0] rsp1_data;
    logic             busy;
    logic [15:0]      grant_cnt0;
    logic [15:0]      grant_cnt1;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, fpu_result,
        output req0_ready, req1_ready, fpu_a, fpu_b, fpu_op,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
               busy, grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, fpu_result,
        input  req0_ready, req1_ready, fpu_a, fpu_b, fpu_op,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
               busy, grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/fpas_tag_pipe.sv
// rtl/fpas_tag_pipe.sv - shift register tracking which requester owns each in-flight core operation
module fpas_tag_pipe
    import fp_addsub_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  fpas_tag_t tag_in,
    output fpas_tag_t tag_out,
    output logic      any_valid
);

    fpas_tag_t stage [DEPTH];

    // Advance every tag one slot per cycle; reset empties the whole pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Pipe is occupied if any slot holds a live tag
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - two-requester round-robin front end for a pipelined FP add/sub core (optional stats: FP_ADDSUB_ARB_STATS_EN)
module fp_addsub_arbiter
    import fp_addsub_pkg::*;
#(
    parameter int WIDTH   = fp_addsub_pkg::WIDTH,
    parameter int LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    fp_addsub_arbiter_if.slave bus
);

    // LATENCY is expected in 1..4; the tag pipe spans the operand register plus the core
    localparam int TAG_DEPTH = LATENCY + 1;

    logic             prio;      // 0: req0 wins a tie, 1: req1 wins a tie
    logic             ready0;
    logic             ready1;
    logic             xfer;
    logic             win_id;
    logic [WIDTH-1:0] fpu_a_q;
    logic [WIDTH-1:0] fpu_b_q;
    logic             fpu_op_q;
    fpas_tag_t        tag_in;
    fpas_tag_t        tag_out;
    logic             pipe_busy;

    // Grant from the valids and pointer only; held off entirely while in reset
    always_comb begin
        ready0 = reset & bus.req0_valid & (~bus.req1_valid | ~prio);
        ready1 = reset & bus.req1_valid & (~bus.req0_valid |  prio);
        xfer   = ready0 | ready1;
        win_id = ready1;
        tag_in.valid = xfer;
        tag_in.id    = win_id;
    end

    // Capture the winner's operands and hand the tie-break to the other requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_op_q <= FP_ADD;
            prio     <= 1'b0;
        end else if (xfer) begin
            fpu_a_q  <= win_id ? bus.req1_a  : bus.req0_a;
            fpu_b_q  <= win_id ? bus.req1_b  : bus.req0_b;
            fpu_op_q <= win_id ? bus.req1_op : bus.req0_op;
            prio     <= ~win_id;
        end
    end

    fpas_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (pipe_busy)
    );

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.fpu_a      = fpu_a_q;
    assign bus.fpu_b      = fpu_b_q;
    assign bus.fpu_op     = fpu_op_q;
    assign bus.rsp0_valid = tag_out.valid & ~tag_out.id;
    assign bus.rsp1_valid = tag_out.valid &  tag_out.id;
    assign bus.rsp0_data  = bus.fpu_result;
    assign bus.rsp1_data  = bus.fpu_result;
    assign bus.busy       = pipe_busy;

`ifdef FP_ADDSUB_ARB_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Saturating per-requester count of accepted operations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (ready0 && cnt0_q != 16'hFFFF) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (ready1 && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
`else
    assign bus.grant_cnt0 = 16'h0000;
    assign bus.grant_cnt1 = 16'h0000;
`endif

endmodule
